// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone command master.
package wb_pkg;

    localparam int WB_AW  = 26;
    localparam int WB_DW  = 32;
    localparam int WB_TMO = 255;

    typedef logic [3:0] beat_len_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WD,
        BEAT,
        DONE,
        ERR
    } wb_state_t;

endpackage

// File: rtl/wb_beat_timer.sv
// Per-beat ack timeout: clearable up-counter whose terminal flag marks the
// final cycle a beat may still be acknowledged.
module wb_beat_timer #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int TW = $clog2(TMO + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Count holds the number of ack-less cycles already spent, so TMO-1 means
    // the current cycle is the TMO-th one without an ack.
    assign last = (count == TW'(TMO - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic burst master: turns one command into 1..16 single beats,
// holding cyc across the burst and aborting a beat that never gets acked.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int AW  = WB_AW,
    parameter int DW  = WB_DW,
    parameter int TMO = WB_TMO
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [3:0]      cmd_len,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            done,
    output logic            err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);

    localparam int SW = DW / 8;

    wb_state_t state;
    beat_len_t beat;
    beat_len_t len;
    logic      tmo_last;

    // An ack restarts the window so every beat gets the full TMO cycles.
    wb_beat_timer #(
        .TMO(TMO)
    ) u_timer (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .clear((state != BEAT) || wb_ack_i),
        .inc  (state == BEAT),
        .last (tmo_last)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            beat       <= '0;
            len        <= '0;
            cmd_ready  <= 1'b0;
            wdat_ready <= 1'b0;
            rdat_valid <= 1'b0;
            rdat       <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= '0;
            wb_sel_o   <= '0;
            wb_dat_o   <= '0;
        end else begin
            rdat_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wb_we_o   <= cmd_we;
                        wb_addr_o <= cmd_addr;
                        wb_sel_o  <= cmd_sel;
                        len       <= cmd_len;
                        beat      <= '0;
                        if (cmd_we) begin
                            wdat_ready <= 1'b1;
                            state      <= WAIT_WD;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= BEAT;
                        end
                    end
                end
                WAIT_WD: begin
                    if (wdat_valid) begin
                        wdat_ready <= 1'b0;
                        wb_dat_o   <= wdat;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        state      <= BEAT;
                    end
                end
                BEAT: begin
                    if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            rdat       <= wb_dat_i;
                            rdat_valid <= 1'b1;
                        end
                        if (beat == len) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            beat      <= beat + 1'b1;
                            wb_addr_o <= wb_addr_o + AW'(SW);
                            // Writes drop stb while fetching the next word but keep the bus.
                            if (wb_we_o) begin
                                wb_stb_o   <= 1'b0;
                                wdat_ready <= 1'b1;
                                state      <= WAIT_WD;
                            end
                        end
                    end else if (tmo_last) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        err      <= 1'b1;
                        state    <= ERR;
                    end
                end
                DONE, ERR: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: inputs change and outputs are sampled on
// the falling edge, so every check sees the state left by the previous rise.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [25:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic        done;
    logic        err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [25:0] wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_out;
    logic        wb_ack;
    logic [31:0] wb_dat_in;

    int checks   = 0;
    int failures = 0;
    int rv_count;
    int done_count;
    int err_count;
    int drop_count;

    wb_cmd_master dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_sel   (cmd_sel),
        .wdat_valid(wdat_valid),
        .wdat_ready(wdat_ready),
        .wdat      (wdat),
        .rdat_valid(rdat_valid),
        .rdat      (rdat),
        .done      (done),
        .err       (err),
        .wb_cyc_o  (wb_cyc),
        .wb_stb_o  (wb_stb),
        .wb_we_o   (wb_we),
        .wb_addr_o (wb_addr),
        .wb_sel_o  (wb_sel),
        .wb_dat_o  (wb_dat_out),
        .wb_ack_i  (wb_ack),
        .wb_dat_i  (wb_dat_in)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [25:0] addr,
                                 input logic [3:0] len, input logic [3:0] sel);
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
    endtask

    // Advance to the next falling edge and tally the one-cycle pulses.
    task automatic step();
        @(negedge clk);
        if (rdat_valid) rv_count++;
        if (done) done_count++;
        if (err) err_count++;
        if (!wb_cyc) drop_count++;
    endtask

    task automatic clearTallies();
        rv_count   = 0;
        done_count = 0;
        err_count  = 0;
        drop_count = 0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_sel    = '0;
        wdat_valid = 1'b0;
        wdat       = '0;
        wb_ack     = 1'b0;
        wb_dat_in  = '0;
        clearTallies();

        // Reset held three cycles while a command is offered.
        applyStimulus(1'b0, 26'h100, 4'd0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_cyc", wb_cyc, 1'b0);
            checkOutput("rst_stb", wb_stb, 1'b0);
            checkOutput("rst_cmd_ready", cmd_ready, 1'b0);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        step();
        checkOutput("post_rst_cmd_ready", cmd_ready, 1'b1);
        checkOutput("post_rst_cyc", wb_cyc, 1'b0);

        // Four-beat read, slave acks every cycle.
        clearTallies();
        applyStimulus(1'b0, 26'h100, 4'd3, 4'hF);
        step();
        cmd_valid = 1'b0;
        checkOutput("rd_latency_stb", wb_stb, 1'b1);
        checkOutput("rd_we", wb_we, 1'b0);
        checkOutput("rd_sel", wb_sel, 4'hF);
        checkOutput("rd_cmd_ready_busy", cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd_addr", wb_addr, 32'h100 + 32'(4 * i));
            checkOutput("rd_cyc", wb_cyc, 1'b1);
            checkOutput("rd_stb", wb_stb, 1'b1);
            wb_ack    = 1'b1;
            wb_dat_in = 32'hA000_0000 + 32'(i);
            step();
            checkOutput("rd_rdat_valid", rdat_valid, 1'b1);
            checkOutput("rd_rdat", rdat, 32'hA000_0000 + 32'(i));
        end
        wb_ack = 1'b0;
        checkOutput("rd_end_cyc", wb_cyc, 1'b0);
        checkOutput("rd_end_stb", wb_stb, 1'b0);
        checkOutput("rd_done", done, 1'b1);
        step();
        checkOutput("rd_done_pulse", done, 1'b0);
        checkOutput("rd_ready_after", cmd_ready, 1'b1);
        checkOutput("rd_rv_count", rv_count, 4);
        checkOutput("rd_done_count", done_count, 1);

        // Two-beat write at the top of the address space, data two cycles late.
        clearTallies();
        applyStimulus(1'b1, 26'h3FF_FFFC, 4'd1, 4'hF);
        step();
        cmd_valid = 1'b0;
        checkOutput("wr_wdat_ready", wdat_ready, 1'b1);
        checkOutput("wr_wait_cyc0", wb_cyc, 1'b0);
        for (int w = 0; w < 2; w++) begin
            checkOutput("wr_wait0_stb", wb_stb, 1'b0);
            step();
        end
        wdat_valid = 1'b1;
        wdat       = 32'hDEAD_0001;
        step();
        wdat_valid = 1'b0;
        checkOutput("wr_b0_stb", wb_stb, 1'b1);
        checkOutput("wr_b0_we", wb_we, 1'b1);
        checkOutput("wr_b0_addr", wb_addr, 32'h3FF_FFFC);
        checkOutput("wr_b0_dat", wb_dat_out, 32'hDEAD_0001);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        checkOutput("wr_wrap_addr", wb_addr, 32'h0);
        checkOutput("wr_mid_ready", wdat_ready, 1'b1);
        for (int w = 0; w < 2; w++) begin
            checkOutput("wr_wait1_cyc", wb_cyc, 1'b1);
            checkOutput("wr_wait1_stb", wb_stb, 1'b0);
            step();
        end
        wdat_valid = 1'b1;
        wdat       = 32'hBEEF_0002;
        step();
        wdat_valid = 1'b0;
        checkOutput("wr_b1_stb", wb_stb, 1'b1);
        checkOutput("wr_b1_dat", wb_dat_out, 32'hBEEF_0002);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        checkOutput("wr_end_cyc", wb_cyc, 1'b0);
        checkOutput("wr_done", done, 1'b1);
        step();
        checkOutput("wr_done_count", done_count, 1);
        checkOutput("wr_rv_count", rv_count, 0);

        // Read whose slave never answers: abort after 255 ack-less cycles.
        clearTallies();
        applyStimulus(1'b0, 26'h200, 4'd0, 4'h3);
        step();
        cmd_valid = 1'b0;
        drop_count = 0;
        for (int i = 0; i < 254; i++) step();
        checkOutput("tmo_cyc_held", drop_count, 0);
        checkOutput("tmo_last_cyc", wb_cyc, 1'b1);
        checkOutput("tmo_last_stb", wb_stb, 1'b1);
        checkOutput("tmo_no_err_yet", err, 1'b0);
        step();
        checkOutput("tmo_err", err, 1'b1);
        checkOutput("tmo_cyc_drop", wb_cyc, 1'b0);
        checkOutput("tmo_stb_drop", wb_stb, 1'b0);
        step();
        checkOutput("tmo_err_count", err_count, 1);
        checkOutput("tmo_rv_count", rv_count, 0);
        checkOutput("tmo_done_count", done_count, 0);
        checkOutput("tmo_ready_after", cmd_ready, 1'b1);

        // Ack arriving on the very last allowed cycle wins over the timeout.
        clearTallies();
        applyStimulus(1'b0, 26'h300, 4'd0, 4'hF);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 254; i++) step();
        wb_ack    = 1'b1;
        wb_dat_in = 32'h0000_5A5A;
        step();
        wb_ack = 1'b0;
        checkOutput("late_ack_done", done, 1'b1);
        checkOutput("late_ack_err", err, 1'b0);
        checkOutput("late_ack_rdat", rdat, 32'h0000_5A5A);
        step();
        checkOutput("late_ack_err_count", err_count, 0);
        checkOutput("late_ack_done_count", done_count, 1);

        // Four-beat write interrupted by reset after the second beat.
        clearTallies();
        applyStimulus(1'b1, 26'h040, 4'd3, 4'hF);
        wdat_valid = 1'b1;
        wdat       = 32'h1111_2222;
        step();
        cmd_valid = 1'b0;
        step();
        checkOutput("rst_wr_latency_stb", wb_stb, 1'b1);
        checkOutput("rst_wr_b0_addr", wb_addr, 32'h040);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        step();
        checkOutput("rst_wr_b1_addr", wb_addr, 32'h044);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        checkOutput("rst_wr_mid_cyc", wb_cyc, 1'b1);
        checkOutput("rst_wr_mid_addr", wb_addr, 32'h048);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        wdat_valid = 1'b0;
        checkOutput("rst_wr_cyc", wb_cyc, 1'b0);
        checkOutput("rst_wr_stb", wb_stb, 1'b0);
        step();
        checkOutput("rst_wr_ready", cmd_ready, 1'b1);
        checkOutput("rst_wr_done_count", done_count, 0);
        checkOutput("rst_wr_err_count", err_count, 0);

        // A fresh single-beat read after the abort.
        applyStimulus(1'b0, 26'h080, 4'd0, 4'hF);
        step();
        cmd_valid = 1'b0;
        checkOutput("post_rst_rd_addr", wb_addr, 32'h080);
        checkOutput("post_rst_rd_stb", wb_stb, 1'b1);
        wb_ack    = 1'b1;
        wb_dat_in = 32'h0000_CAFE;
        step();
        wb_ack = 1'b0;
        checkOutput("post_rst_rd_done", done, 1'b1);
        checkOutput("post_rst_rd_rdat", rdat, 32'h0000_CAFE);
        step();

        // A stray ack while idle must be ignored.
        clearTallies();
        wb_ack = 1'b1;
        step();
        step();
        wb_ack = 1'b0;
        checkOutput("idle_ack_rv", rv_count, 0);
        checkOutput("idle_ack_done", done_count, 0);
        checkOutput("idle_ack_cyc", wb_cyc, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter AW, default 26, Wishbone byte-address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width; DW/8 byte lanes.
REQ-003 SHALL have parameter TMO, default 255, maximum cycles to wait for wb_ack_i per beat.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  in  1  command offered.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_we  in  1  1=write burst, 0=read burst.
REQ-009 SHALL have port cmd_addr  in  AW  start byte address, DW/8-aligned.
REQ-010 SHALL have port cmd_len  in  4  beats minus one (0..15 => 1..16 beats).
REQ-011 SHALL have port cmd_sel  in  DW/8  byte enables applied to every beat.
REQ-012 SHALL have port wdat_valid / wdat_ready  in/out  1  write-data handshake.
REQ-013 SHALL have port wdat  in  DW  write data for the current beat.
REQ-014 SHALL have port rdat_valid  out  1  one-cycle pulse per returned read beat; rdat  out  DW.
REQ-015 SHALL have port done / err  out  1  one-cycle pulses: burst complete; burst aborted on timeout.
REQ-016 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  out  1; wb_addr_o  out  AW; wb_sel_o  out  DW/8; wb_dat_o  out  DW.
REQ-017 SHALL have ports wb_ack_i  in  1; wb_dat_i  in  DW.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_WD, BEAT, DONE, ERR.
REQ-019 In IDLE, cmd_ready SHALL be 1; on handshake latch we/addr/len/sel, clear beat counter, go to BEAT for a read and WAIT_WD for a write.
REQ-020 In WAIT_WD, wdat_ready SHALL be 1; on wdat_valid latch wdat into wb_dat_o and go to BEAT next cycle.
REQ-021 In BEAT, wb_cyc_o=wb_stb_o=1 with registered addr/we/sel/dat; stb SHALL never be 1 while cyc is 0 (Rule 3.25).
REQ-022 In BEAT, on wb_ack_i: for a read, rdat<=wb_dat_i and rdat_valid pulses the following cycle.
REQ-023 On ack, if beat counter == len, go to DONE; else increment the counter and add DW/8 to the address, modulo 2^AW.
REQ-024 On a non-final ack, a read SHALL stay in BEAT with stb held.
REQ-025 On a non-final ack, a write SHALL go to WAIT_WD with stb=0 and cyc held at 1 across the burst.
REQ-026 wb_cyc_o SHALL remain 1 from the first BEAT cycle through the final ack and drop in DONE/ERR.
REQ-027 Beat timeout counter SHALL clear on entry to BEAT and increment each BEAT cycle without ack.
REQ-028 When the timeout counter reaches TMO, the FSM SHALL go to ERR with cyc/stb deasserted next cycle.
REQ-029 An ack arriving on the same cycle the timeout counter reaches TMO SHALL take precedence (beat completes).
REQ-030 wb_ack_i outside BEAT SHALL be ignored.
REQ-031 DONE SHALL pulse done for 1 cycle; ERR SHALL pulse err for 1 cycle; both return to IDLE.
REQ-032 Minimum latency: cmd handshake -> first stb = 1 cycle for a read; 2 cycles for a write with wdat already valid.

Reset
REQ-033 While wb_rst_i=1, state SHALL be IDLE, outputs and counters 0, and wb_cyc_o=wb_stb_o=0 (Rule 3.00).
REQ-034 The master SHALL treat reset as lasting at least one cycle and require no minimum.
REQ-035 Reset asserted mid-burst SHALL abort the burst the next cycle without pulsing done or err.
REQ-036 cmd_ready SHALL be 0 during reset and 1 the first cycle after wb_rst_i falls.

Structure
REQ-037 Shared package wb_pkg SHALL hold the FSM state enum, default AW/DW/TMO constants, and a beat-length type.
REQ-038 Sub-module wb_beat_timer (loadable counter with terminal flag) SHALL implement the timeout; all other logic SHALL be in one module.

Verification
REQ-039 Reset held 3 cycles with cmd_valid=1 -> cyc/stb=0 throughout; cmd_ready=1 the cycle after release.
REQ-040 Read cmd addr=0x100, len=3, slave ack every cycle -> addresses 0x100,0x104,0x108,0x10C; 4 rdat_valid pulses; cyc continuous; done once.
REQ-041 Write cmd addr=0x3FFFFFC, len=1, wdat delayed 2 cycles per beat -> stb low during waits, cyc high, second address wraps to 0x0000000, done once.
REQ-042 Read, no ack for 255 cycles -> err pulse, cyc/stb fall, no rdat_valid, cmd_ready=1 afterward.
REQ-043 Ack on exactly cycle 255 -> beat completes, no err.
REQ-044 Reset mid-write after beat 2 of 4 -> cyc/stb=0 next cycle, no done/err; a subsequent command executes normally.
